// File: rtl/mc_control_if.sv
// -----------------------------------------------------------------------------
// mc_control_if
// Bundles the multicycle controller's instruction/handshake inputs and its
// datapath control outputs into one interface.
//
// Modports:
//   master : the controller (mc_control). Receives opcode and mem_ready, drives
//            every control, status and debug signal.
//   slave  : the datapath/memory side. Drives opcode and mem_ready, receives
//            the controls.
//
// Signals:
//   opcode        [6:0] instruction[6:0] from the instruction register
//   mem_ready           memory completes the current access this cycle
//   pc_write            unconditional PC load
//   pc_write_cond       PC load if the ALU compare is true
//   iord                memory address select: 0=PC, 1=ALUOut
//   mem_read            memory read request
//   mem_write           memory write request
//   ir_write            instruction register load
//   mem_to_reg          writeback select: 1=MDR, 0=ALUOut
//   reg_write           register file write enable
//   alu_src_a           0=PC, 1=rs1
//   alu_src_b     [1:0] 00=rs2, 01=constant 4, 10=immediate
//   alu_op        [1:0] 00=add, 01=branch compare, 10=R-type funct, 11=I-type funct
//   instr_done          one-cycle pulse when an instruction retires
//   mem_err             one-cycle pulse on memory timeout
//   illegal_instr       sticky illegal-opcode flag
//   state         [3:0] current controller state, for debug
// -----------------------------------------------------------------------------
interface mc_control_if;

   logic [6:0] opcode;
   logic       mem_ready;

   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;

   logic       instr_done;
   logic       mem_err;
   logic       illegal_instr;
   logic [3:0] state;

   modport master (
      input  opcode,
      input  mem_ready,
      output pc_write,
      output pc_write_cond,
      output iord,
      output mem_read,
      output mem_write,
      output ir_write,
      output mem_to_reg,
      output reg_write,
      output alu_src_a,
      output alu_src_b,
      output alu_op,
      output instr_done,
      output mem_err,
      output illegal_instr,
      output state
   );

   modport slave (
      output opcode,
      output mem_ready,
      input  pc_write,
      input  pc_write_cond,
      input  iord,
      input  mem_read,
      input  mem_write,
      input  ir_write,
      input  mem_to_reg,
      input  reg_write,
      input  alu_src_a,
      input  alu_src_b,
      input  alu_op,
      input  instr_done,
      input  mem_err,
      input  illegal_instr,
      input  state
   );

endinterface

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multicycle controller for the RV32 integer subset (R-type, I-type ALU, loads,
// stores, branches). Steps a shared-ALU, single-memory datapath through fetch,
// decode, execute, memory and writeback, one state per cycle, and drives the
// datapath mux selects and write enables. Memory accesses wait on mem_ready and
// are aborted after MEM_TIMEOUT cycles without it.
//
// Parameters:
//   MEM_TIMEOUT  max cycles an access waits for mem_ready before abort (>= 2)
//   CNT_W        wait counter width; must hold MEM_TIMEOUT-1
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   mc_control_if.master: opcode/mem_ready in, controls and status out
//
// Build option:
//   MC_ILLEGAL_TRAP_EN  when defined, an unknown opcode in DECODE parks the FSM
//                       in TRAP and sets the sticky illegal_instr flag. When
//                       undefined, an unknown opcode retires as a NOP and
//                       illegal_instr is tied low.
// -----------------------------------------------------------------------------
module mc_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input logic          clk,
   input logic          rst,
   mc_control_if.master bus
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecR   = 4'd6,
      StExecI   = 4'd7,
      StAluWb   = 4'd8,
      StBranch  = 4'd9,
      StTrap    = 4'd10
   } state_t;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             err_q;
   logic             timeout;

   // Last allowed wait cycle with no ready: the access is abandoned.
   assign timeout = (cnt_q == CntLast) && !bus.mem_ready;

`ifdef MC_ILLEGAL_TRAP_EN
   logic illegal_q;
   assign bus.illegal_instr = illegal_q;
`else
   assign bus.illegal_instr = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // State machine, wait counter and registered status pulses
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // Counter is zero everywhere except while waiting inside an access, so
         // every entry into FETCH/MEM_RD/MEM_WR starts from a clean count.
         cnt_q  <= '0;

         case (state_q)
            StFetch: begin
               if (bus.mem_ready) begin
                  state_q <= StDecode;
               end else if (timeout) begin
                  state_q <= StFetch;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            StDecode: begin
               case (bus.opcode)
                  OpR:             state_q <= StExecR;
                  OpI:             state_q <= StExecI;
                  OpLoad, OpStore: state_q <= StMemAddr;
                  OpBranch:        state_q <= StBranch;
                  default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                     state_q   <= StTrap;
                     illegal_q <= 1'b1;
`else
                     // Unknown opcode retires as a NOP.
                     state_q <= StFetch;
                     done_q  <= 1'b1;
`endif
                  end
               endcase
            end

            StMemAddr: begin
               state_q <= (bus.opcode == OpLoad) ? StMemRd : StMemWr;
            end

            StMemRd: begin
               if (bus.mem_ready) begin
                  state_q <= StMemWb;
               end else if (timeout) begin
                  state_q <= StFetch;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            StMemWb: begin
               state_q <= StFetch;
               done_q  <= 1'b1;
            end

            StMemWr: begin
               if (bus.mem_ready) begin
                  state_q <= StFetch;
                  done_q  <= 1'b1;
               end else if (timeout) begin
                  state_q <= StFetch;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            StExecR: state_q <= StAluWb;

            StExecI: state_q <= StAluWb;

            StAluWb: begin
               state_q <= StFetch;
               done_q  <= 1'b1;
            end

            StBranch: begin
               state_q <= StFetch;
               done_q  <= 1'b1;
            end

            StTrap: state_q <= StTrap;

            // Codes 11-15 cannot be reached; recover by refetching.
            default: state_q <= StFetch;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Control decode. Moore on state except the FETCH loads, which follow
   // mem_ready directly. Gated by rst so requests drop the moment reset rises.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;

      if (!rst) begin
         case (state_q)
            StFetch: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            StDecode: begin
               bus.alu_src_b = 2'b10;
            end
            StMemAddr: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
            end
            StMemRd: begin
               bus.mem_read = 1'b1;
               bus.iord     = 1'b1;
            end
            StMemWb: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            StMemWr: begin
               bus.mem_write = 1'b1;
               bus.iord      = 1'b1;
            end
            StExecR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b10;
            end
            StExecI: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
               bus.alu_op    = 2'b11;
            end
            StAluWb: begin
               bus.reg_write = 1'b1;
            end
            StBranch: begin
               bus.alu_src_a     = 1'b1;
               bus.alu_op        = 2'b01;
               bus.pc_write_cond = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.instr_done = done_q;
   assign bus.mem_err    = err_q;
   assign bus.state      = state_q;

endmodule
